// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS transmit front end.
//   pair_t        : one differential output pair (p = true leg, n = complement).
//   MODE_TRUE /
//   MODE_EMULATED : buffer-type selectors handed to every lvds_out.
//   word_mode_e   : what a lane loads at a word boundary.
//   train_pattern : alternating 1010... starting at the MSB of a w-bit word.
package lvds_pkg;

  typedef struct packed {
    logic p;
    logic n;
  } pair_t;

  // Character constants packed into 64 bits so they can be compared at
  // elaboration time like any other parameter value.
  localparam logic [63:0] MODE_TRUE     = {32'h0, "True"};
  localparam logic [63:0] MODE_EMULATED = "Emulated";

  typedef enum logic [1:0] {
    WORD_IDLE  = 2'd0,
    WORD_DATA  = 2'd1,
    WORD_TRAIN = 2'd2
  } word_mode_e;

  function automatic logic [63:0] train_pattern(input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = (((w - 1 - i) % 2) == 0);
    end
    return r;
  endfunction

endpackage

// File: rtl/lvds_out.sv
// Single-bit LVDS output buffer.
//   Mode : MODE_TRUE uses a native differential buffer; MODE_EMULATED drives
//          the pair from two single-ended outputs with the complement built
//          in fabric. Both present n = ~p at the pins.
//   p    : bit to transmit.
//   pad  : differential pair.
module lvds_out
  import lvds_pkg::*;
#(
  parameter logic [63:0] Mode = MODE_TRUE
) (
  input  logic  p,
  output pair_t pad
);

  generate
    if (Mode == MODE_EMULATED) begin : g_emulated
      logic n_leg;
      assign n_leg = ~p;
      assign pad.p = p;
      assign pad.n = n_leg;
    end else begin : g_true
      assign pad = '{p: p, n: ~p};
    end
  endgenerate

endmodule

// File: rtl/lvds_tx_serializer.sv
// Multi-lane LVDS serializer with forwarded frame clock and training mode.
//   clk       : serial bit clock, one bit per lane per cycle.
//   rst_n     : asynchronous active-low reset.
//   data      : one Width-bit word per lane, lane 0 in the lowest slice.
//   valid     : data is valid.
//   ready     : data is taken this cycle.
//   train     : level; selects TrainWord at the next word boundary.
//   underflow : one-cycle pulse after a boundary that loaded IdleWord for
//               lack of valid data.
//   clk_pair  : forwarded frame clock (high for the first ceil(Width/2) bits).
//   pairs     : serial data lanes.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// ready is high for exactly one cycle per word (the last bit of the word in
// flight), depends only on flops and train, and never on valid. The serial
// stream never stalls: if no transfer happens at a boundary, IdleWord or
// TrainWord is sent instead.
module lvds_tx_serializer
  import lvds_pkg::*;
#(
  parameter int               Lanes     = 4,
  parameter int               Width     = 8,
  parameter logic [63:0]      Mode      = MODE_TRUE,
  parameter bit               MsbFirst  = 1'b0,
  parameter logic [Width-1:0] IdleWord  = '0,
  parameter logic [Width-1:0] TrainWord = Width'(train_pattern(Width))
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [Lanes*Width-1:0]   data,
  input  logic                     valid,
  output logic                     ready,
  input  logic                     train,
  output logic                     underflow,
  output pair_t                    clk_pair,
  output pair_t [Lanes-1:0]        pairs
);

  localparam int            CntW     = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'((Width + 1) / 2);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             frame_q, frame_d;
  logic             underflow_q, underflow_d;
  logic [Width-1:0] sr_q [Lanes];
  logic [Width-1:0] sr_d [Lanes];

  logic             boundary;
  logic             ready_int;
  word_mode_e       word_mode;
  logic [Lanes:0]   out_bit;

  always_comb begin
    boundary  = (cnt_q == LastCnt);
    ready_int = boundary && armed_q && !train;
    cnt_d     = boundary ? '0 : cnt_q + CntW'(1);
    armed_d   = 1'b1;

    if (train)                  word_mode = WORD_TRAIN;
    else if (valid && ready_int) word_mode = WORD_DATA;
    else                        word_mode = WORD_IDLE;

    // The very first boundary after reset is not armed, so its IdleWord
    // is startup filler rather than an underflow.
    underflow_d = boundary && (word_mode == WORD_IDLE) && armed_q;

    // Registered from the next count so the clock lane lines up with the
    // bit index that will be on the data lanes next cycle.
    frame_d = (cnt_d < HalfCnt);

    for (int l = 0; l < Lanes; l++) begin
      if (boundary) begin
        case (word_mode)
          WORD_TRAIN: sr_d[l] = TrainWord;
          WORD_DATA:  sr_d[l] = data[l*Width +: Width];
          default:    sr_d[l] = IdleWord;
        endcase
      end else if (MsbFirst) begin
        sr_d[l] = sr_q[l] << 1;
      end else begin
        sr_d[l] = sr_q[l] >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= LastCnt;
      armed_q     <= 1'b0;
      frame_q     <= 1'b0;
      underflow_q <= 1'b0;
      for (int l = 0; l < Lanes; l++) sr_q[l] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      frame_q     <= frame_d;
      underflow_q <= underflow_d;
      for (int l = 0; l < Lanes; l++) sr_q[l] <= sr_d[l];
    end
  end

  assign ready     = ready_int;
  assign underflow = underflow_q;

  // Output bits come straight from flops so the pins see no logic glitches.
  genvar g;
  generate
    for (g = 0; g <= Lanes; g++) begin : g_out
      if (g < Lanes) begin : g_lane
        assign out_bit[g] = MsbFirst ? sr_q[g][Width-1] : sr_q[g][0];
        lvds_out #(.Mode(Mode)) u_lane (
          .p   (out_bit[g]),
          .pad (pairs[g])
        );
      end else begin : g_clk
        assign out_bit[g] = frame_q;
        lvds_out #(.Mode(Mode)) u_clk (
          .p   (out_bit[g]),
          .pad (clk_pair)
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_lvds_tx_serializer.sv
module tb_lvds_tx_serializer;
  import lvds_pkg::*;

  localparam int L  = 2;
  localparam int W  = 8;
  localparam int EW = 3 + 2 * L;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [L*W-1:0] data  = '0;
  logic           valid = 1'b0;
  logic           train = 1'b0;

  logic             ready_a, uf_a, ready_b, uf_b;
  pair_t            cp_a, cp_b;
  pair_t [L-1:0]    pr_a, pr_b;

  lvds_tx_serializer #(.Lanes(L), .Width(W), .MsbFirst(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready_a),
    .train(train), .underflow(uf_a), .clk_pair(cp_a), .pairs(pr_a)
  );

  lvds_tx_serializer #(.Lanes(L), .Width(W), .MsbFirst(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready_b),
    .train(train), .underflow(uf_b), .clk_pair(cp_b), .pairs(pr_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One entry per serial cycle: {underflow, clk.p, clk.n, lane p's, lane n's}.
  task automatic push_period(input logic [L*W-1:0] w, input logic uf);
    for (int i = 0; i < W; i++) begin
      logic [L-1:0] pa, pb;
      logic c, u;
      for (int l = 0; l < L; l++) begin
        pa[l] = w[l*W + i];
        pb[l] = w[l*W + W - 1 - i];
      end
      c = (i < 4);
      u = (i == 0) && uf;
      exp_a_q.push_back({u, c, ~c, pa, ~pa});
      exp_b_q.push_back({u, c, ~c, pb, ~pb});
    end
  endtask

  // Monitor: the serial stream presents a new bit every cycle.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && exp_a_q.size() > 0) begin
        e = exp_a_q.pop_front();
        chk("stream_lsb", 32'({uf_a, cp_a.p, cp_a.n, pr_a[1].p, pr_a[0].p, pr_a[1].n, pr_a[0].n}), 32'(e));
      end
      if (mon_en && exp_b_q.size() > 0) begin
        e = exp_b_q.pop_front();
        chk("stream_msb", 32'({uf_b, cp_b.p, cp_b.n, pr_b[1].p, pr_b[0].p, pr_b[1].n, pr_b[0].n}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_reset_vals(input string name);
    chk({name, "_a"}, 32'({cp_a.p, cp_a.n, pr_a[1].p, pr_a[0].p, pr_a[1].n, pr_a[0].n, ready_a, uf_a}), 32'b01001100);
    chk({name, "_b"}, 32'({cp_b.p, cp_b.n, pr_b[1].p, pr_b[0].p, pr_b[1].n, pr_b[0].n, ready_b, uf_b}), 32'b01001100);
  endtask

  // Caller has just driven rst_n low.
  task automatic finish_reset();
    #1;
    chk_reset_vals("reset_immediate");
    repeat (2) begin
      @(negedge clk);
      chk_reset_vals("reset_hold");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_period('0, 1'b0);   // startup IdleWord, no underflow
    mon_en = 1'b1;
  endtask

  // One word period: starts just after a boundary edge, ends just after the next.
  task automatic word_period(input logic v, input logic t, input int t_at, input logic [L*W-1:0] d);
    valid = v;
    data  = d;
    for (int i = 0; i < W; i++) begin
      if (i == t_at) train = t;
      @(negedge clk);
      chk("ready_a", 32'(ready_a), 32'((i == W - 1) && !train));
      chk("ready_b", 32'(ready_b), 32'((i == W - 1) && !train));
      @(posedge clk); #1;
    end
    push_period(t ? {L{8'hAA}} : (v ? d : '0), !t && !v);
  endtask

  task automatic reset_mid(input int at_bit);
    valid = 1'b0;
    for (int i = 0; i < at_bit; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    rst_n = 1'b0;
    finish_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    finish_reset();
    word_period(1'b1, 1'b0, 0, {8'h3C, 8'hA5});   // single transfer
    word_period(1'b0, 1'b0, 0, '0);                // underflow
    word_period(1'b1, 1'b0, 0, {8'hFE, 8'h01});   // back-to-back, valid held
    word_period(1'b1, 1'b0, 0, {8'h7F, 8'h80});
    word_period(1'b1, 1'b0, 0, {8'h00, 8'hFF});
    word_period(1'b1, 1'b1, 3, {8'h12, 8'h34});   // train raised at bit 3
    word_period(1'b1, 1'b0, 0, {8'hC3, 8'h5A});   // train dropped, data resumes
    word_period(1'b0, 1'b0, 0, '0);
    reset_mid(5);                                  // reset at bit 5
    word_period(1'b1, 1'b0, 0, {8'h0F, 8'hF0});
    word_period(1'b0, 1'b0, 0, '0);
    valid = 1'b0;
    for (int k = 0; k < 20 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); k++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_a_q.size() + exp_b_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
